// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-size encodings, MEM-stage FSM
// states, default data/register widths and byte-lane helper functions.
package mips_pkg;

   localparam int MIPS_DATA_W = 32;
   localparam int MIPS_REG_W  = 5;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_e;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: size_mask = 8'h01;
         SZ_HALF: size_mask = 8'h03;
         SZ_WORD: size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] sz);
      case (sz)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = off[0];
         SZ_WORD: is_misaligned = |off[1:0];
         default: is_misaligned = |off;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: replicated store data, byte enables and
// sign/zero-extended load data for a given address offset and access size.
module mem_lane_align
   import mips_pkg::*;
#(
   parameter int  DATA_W = MIPS_DATA_W,
   localparam int NB     = DATA_W / 8,
   localparam int OFF_W  = $clog2(NB)
) (
   input  logic [OFF_W-1:0]  off,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] st_data,
   output logic [NB-1:0]     be,
   output logic [DATA_W-1:0] ld_data
);

   logic [NB-1:0]     mask_s;
   logic [DATA_W-1:0] shifted_s;
   logic              sign_s;
   int                nbits_s;

   // Store path: replicate the right-aligned datum across every lane.
   always_comb begin
      st_data = wdata;
      case (size)
         SZ_BYTE: for (int i = 0; i < NB; i++)     st_data[8*i +: 8]   = wdata[7:0];
         SZ_HALF: for (int i = 0; i < NB/2; i++)   st_data[16*i +: 16] = wdata[15:0];
         SZ_WORD: for (int i = 0; i < NB/4; i++)   st_data[32*i +: 32] = wdata[31:0];
         default: st_data = wdata;
      endcase
   end

   // Byte enables: the shift drops lanes past the word, so misaligned
   // accesses are silently truncated rather than wrapped.
   always_comb begin
      mask_s = NB'(size_mask(size));
      be     = mask_s << off;
   end

   // Load path: right-align the addressed lanes, then extend from the access MSB.
   always_comb begin
      shifted_s = rdata >> {off, 3'b000};
      case (size)
         SZ_BYTE: nbits_s = 8;
         SZ_HALF: nbits_s = 16;
         SZ_WORD: nbits_s = 32;
         default: nbits_s = DATA_W;
      endcase
      sign_s  = shifted_s[nbits_s-1] & ~is_unsigned;
      ld_data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i < nbits_s) begin
            ld_data[i] = shifted_s[i];
         end else begin
            ld_data[i] = sign_s;
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM pipeline stage: handshaked data-memory access with byte lanes,
// upstream stall, registered MEM/WB bundle and EX-side forwarding taps.
// Optional macro MEM_ALIGN_CHECK_EN adds misalignment trapping and wb_misalign.
module mem_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = MIPS_DATA_W,
   parameter int ADDR_W = 32,
   parameter int REG_W  = MIPS_REG_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ex_valid,
   input  logic [DATA_W-1:0]   ex_alu_out,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic [REG_W-1:0]    ex_wreg,
   input  logic                ex_reg_write,
   input  logic                ex_mem_read,
   input  logic                ex_mem_write,
   input  logic [1:0]          ex_size,
   input  logic                ex_unsigned,
   output logic                mem_stall,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic [DATA_W-1:0]   dmem_wdata,
   output logic [DATA_W/8-1:0] dmem_be,
   input  logic                dmem_ready,
   input  logic [DATA_W-1:0]   dmem_rdata,
   output logic [DATA_W-1:0]   fwd_alu_out,
   output logic [REG_W-1:0]    fwd_wreg,
   output logic                fwd_reg_write,
`ifdef MEM_ALIGN_CHECK_EN
   output logic                wb_misalign,
`endif
   output logic                wb_valid,
   output logic                wb_reg_write,
   output logic                wb_memto_reg,
   output logic [REG_W-1:0]    wb_wreg,
   output logic [DATA_W-1:0]   wb_alu_out,
   output logic [DATA_W-1:0]   wb_rdata
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   mem_state_e state_q, state_d;

   logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
   logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
   logic [NB-1:0]     hold_be_q,    hold_be_d;
   logic              hold_we_q,    hold_we_d;
   logic [DATA_W-1:0] hold_alu_q,   hold_alu_d;
   logic [REG_W-1:0]  hold_wreg_q,  hold_wreg_d;
   logic              hold_rw_q,    hold_rw_d;
   logic [1:0]        hold_size_q,  hold_size_d;
   logic              hold_uns_q,   hold_uns_d;

   logic              wb_valid_q,   wb_valid_d;
   logic              wb_rw_q,      wb_rw_d;
   logic              wb_m2r_q,     wb_m2r_d;
   logic [REG_W-1:0]  wb_wreg_q,    wb_wreg_d;
   logic [DATA_W-1:0] wb_alu_q,     wb_alu_d;
   logic [DATA_W-1:0] wb_rdata_q,   wb_rdata_d;
`ifdef MEM_ALIGN_CHECK_EN
   logic              wb_mis_q,     wb_mis_d;
`endif

   logic              busy_s;
   logic              is_mem_s;
   logic              misalign_s;
   logic [OFF_W-1:0]  ex_off_s;
   logic [OFF_W-1:0]  la_off_s;
   logic [1:0]        la_size_s;
   logic              la_uns_s;
   logic [DATA_W-1:0] st_data_s;
   logic [NB-1:0]     be_s;
   logic [DATA_W-1:0] ld_data_s;

   assign busy_s   = (state_q == ST_BUSY);
   assign is_mem_s = ex_mem_read | ex_mem_write;
   assign ex_off_s = ex_alu_out[OFF_W-1:0];

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_s = is_mem_s & is_misaligned(3'(ex_off_s), ex_size);
`else
   assign misalign_s = 1'b0;
`endif

   // One aligner serves both directions: EX fields while idle, hold fields while busy.
   assign la_off_s  = busy_s ? hold_addr_q[OFF_W-1:0] : ex_off_s;
   assign la_size_s = busy_s ? hold_size_q : ex_size;
   assign la_uns_s  = busy_s ? hold_uns_q  : ex_unsigned;

   mem_lane_align #(.DATA_W(DATA_W)) u_align (
      .off         (la_off_s),
      .size        (la_size_s),
      .is_unsigned (la_uns_s),
      .wdata       (ex_wdata),
      .rdata       (dmem_rdata),
      .st_data     (st_data_s),
      .be          (be_s),
      .ld_data     (ld_data_s)
   );

   // FSM next state, hold-register capture and MEM/WB bundle update.
   always_comb begin
      state_d      = state_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      hold_be_d    = hold_be_q;
      hold_we_d    = hold_we_q;
      hold_alu_d   = hold_alu_q;
      hold_wreg_d  = hold_wreg_q;
      hold_rw_d    = hold_rw_q;
      hold_size_d  = hold_size_q;
      hold_uns_d   = hold_uns_q;
      wb_valid_d   = 1'b0;
      wb_rw_d      = wb_rw_q;
      wb_m2r_d     = wb_m2r_q;
      wb_wreg_d    = wb_wreg_q;
      wb_alu_d     = wb_alu_q;
      wb_rdata_d   = wb_rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
      wb_mis_d     = wb_mis_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ex_valid && is_mem_s && !misalign_s) begin
               state_d      = ST_BUSY;
               hold_addr_d  = ADDR_W'(ex_alu_out);
               hold_wdata_d = st_data_s;
               hold_be_d    = be_s;
               hold_we_d    = ex_mem_write;
               hold_alu_d   = ex_alu_out;
               hold_wreg_d  = ex_wreg;
               hold_rw_d    = ex_reg_write;
               hold_size_d  = ex_size;
               hold_uns_d   = ex_unsigned;
            end else if (ex_valid) begin
               wb_valid_d = 1'b1;
               wb_rw_d    = ex_reg_write & ~misalign_s;
               wb_m2r_d   = 1'b0;
               wb_wreg_d  = ex_wreg;
               wb_alu_d   = ex_alu_out;
               wb_rdata_d = '0;
`ifdef MEM_ALIGN_CHECK_EN
               wb_mis_d   = misalign_s;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (dmem_ready) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b1;
               wb_rw_d    = hold_rw_q & ~hold_we_q;
               wb_m2r_d   = ~hold_we_q;
               wb_wreg_d  = hold_wreg_q;
               wb_alu_d   = hold_alu_q;
               wb_rdata_d = hold_we_q ? '0 : ld_data_s;
`ifdef MEM_ALIGN_CHECK_EN
               wb_mis_d   = 1'b0;
`endif
            end else begin
               state_d = ST_BUSY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, hold and WB registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         hold_be_q    <= '0;
         hold_we_q    <= 1'b0;
         hold_alu_q   <= '0;
         hold_wreg_q  <= '0;
         hold_rw_q    <= 1'b0;
         hold_size_q  <= 2'd0;
         hold_uns_q   <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_rw_q      <= 1'b0;
         wb_m2r_q     <= 1'b0;
         wb_wreg_q    <= '0;
         wb_alu_q     <= '0;
         wb_rdata_q   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
         wb_mis_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
         hold_be_q    <= hold_be_d;
         hold_we_q    <= hold_we_d;
         hold_alu_q   <= hold_alu_d;
         hold_wreg_q  <= hold_wreg_d;
         hold_rw_q    <= hold_rw_d;
         hold_size_q  <= hold_size_d;
         hold_uns_q   <= hold_uns_d;
         wb_valid_q   <= wb_valid_d;
         wb_rw_q      <= wb_rw_d;
         wb_m2r_q     <= wb_m2r_d;
         wb_wreg_q    <= wb_wreg_d;
         wb_alu_q     <= wb_alu_d;
         wb_rdata_q   <= wb_rdata_d;
`ifdef MEM_ALIGN_CHECK_EN
         wb_mis_q     <= wb_mis_d;
`endif
      end
   end

   assign mem_stall     = busy_s;
   assign dmem_req      = busy_s;
   assign dmem_we       = busy_s & hold_we_q;
   assign dmem_addr     = hold_addr_q;
   assign dmem_wdata    = hold_wdata_q;
   assign dmem_be       = busy_s ? hold_be_q : '0;

   assign fwd_alu_out   = ex_alu_out;
   assign fwd_wreg      = ex_wreg;
   assign fwd_reg_write = ex_valid & ex_reg_write;

   assign wb_valid      = wb_valid_q;
   assign wb_reg_write  = wb_rw_q;
   assign wb_memto_reg  = wb_m2r_q;
   assign wb_wreg       = wb_wreg_q;
   assign wb_alu_out    = wb_alu_q;
   assign wb_rdata      = wb_rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign wb_misalign   = wb_mis_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed EX bundles, a latency-programmable
// memory responder, and a monitor that checks every WB bundle against a queue.
module tb_mem_stage;

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic [4:0]  wreg;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        mis;
   } wb_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_unsigned;
   logic [31:0] ex_alu_out, ex_wdata;
   logic [4:0]  ex_wreg;
   logic [1:0]  ex_size;
   logic        mem_stall, dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] fwd_alu_out;
   logic [4:0]  fwd_wreg;
   logic        fwd_reg_write;
   logic        wb_valid, wb_reg_write, wb_memto_reg, mis_act;
   logic [4:0]  wb_wreg;
   logic [31:0] wb_alu_out, wb_rdata;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ready_lat = 1;
   int busy_cnt = 0;
   int stall_cnt = 0;
   int req_cycles = 0;
   int pushed = 0;
   int popped = 0;
   int last_pop = 0;
   int prev_pop = 0;
   int accept_cyc = 0;
   logic [3:0]  cap_be;
   logic [31:0] cap_wd, cap_addr;
   logic        cap_we;
   wb_t exp_q[$];

   mem_stage dut (
      .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
      .ex_wdata(ex_wdata), .ex_wreg(ex_wreg), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_size(ex_size),
      .ex_unsigned(ex_unsigned), .mem_stall(mem_stall), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .fwd_alu_out(fwd_alu_out), .fwd_wreg(fwd_wreg), .fwd_reg_write(fwd_reg_write),
`ifdef MEM_ALIGN_CHECK_EN
      .wb_misalign(mis_act),
`endif
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_memto_reg(wb_memto_reg),
      .wb_wreg(wb_wreg), .wb_alu_out(wb_alu_out), .wb_rdata(wb_rdata)
   );

`ifndef MEM_ALIGN_CHECK_EN
   assign mis_act = 1'b0;
`endif

   initial forever #5 clock = ~clock;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Memory responder: raises ready on the ready_lat-th request cycle.
   initial begin
      dmem_ready = 1'b0;
      forever begin
         @(negedge clock);
         if (mem_stall) stall_cnt++;
         if (dmem_req) begin
            req_cycles++;
            busy_cnt++;
            if (busy_cnt == ready_lat) begin
               dmem_ready = 1'b1;
               cap_be   = dmem_be;
               cap_wd   = dmem_wdata;
               cap_we   = dmem_we;
               cap_addr = dmem_addr;
            end else begin
               dmem_ready = 1'b0;
            end
         end else begin
            busy_cnt   = 0;
            dmem_ready = 1'b0;
         end
      end
   end

   // Monitor: pops and compares each presented WB bundle.
   initial forever begin
      @(negedge clock);
      if (!reset && wb_valid) begin
         wb_t act, exp;
         act = '{wb_reg_write, wb_memto_reg, wb_wreg, wb_alu_out, wb_rdata, mis_act};
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL wb_unexpected: got bundle %0h with empty scoreboard", act);
         end else begin
            exp = exp_q.pop_front();
            popped++;
            prev_pop = last_pop;
            last_pop = cyc;
            if (act !== exp) begin
               fails++;
               $display("FAIL wb_bundle: got rw=%0b m2r=%0b wreg=%0d alu=%h rdata=%h mis=%0b want rw=%0b m2r=%0b wreg=%0d alu=%h rdata=%h mis=%0b",
                        act.rw, act.m2r, act.wreg, act.alu, act.rdata, act.mis,
                        exp.rw, exp.m2r, exp.wreg, exp.alu, exp.rdata, exp.mis);
            end
         end
      end
   end

   task automatic push(input logic rw, input logic m2r, input logic [4:0] wreg,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic mis);
      exp_q.push_back('{rw, m2r, wreg, alu, rdata, mis});
      pushed++;
   endtask

   // Presents one bundle and holds it until the stage accepts it.
   task automatic send(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                       input logic rw, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns);
      int n;
      logic st;
      ex_valid = 1'b1; ex_alu_out = alu; ex_wdata = wd; ex_wreg = wreg;
      ex_reg_write = rw; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz; ex_unsigned = uns;
      n = 0;
      do begin
         @(negedge clock);
         st = mem_stall;
         @(posedge clock);
         n++;
      end while (st && n < 50);
      if (st) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: stall still %0b after %0d cycles", st, n);
      end
      #1;
      accept_cyc = cyc;
      ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clock);
         n++;
      end
      check("drain", 128'(exp_q.size()), 128'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int s0, r0;
      reset = 1'b1;
      ex_valid = 1'b0; ex_alu_out = 32'd0; ex_wdata = 32'd0; ex_wreg = 5'd0;
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_size = 2'd0; ex_unsigned = 1'b0; dmem_rdata = 32'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_outputs",
            128'({dmem_req, dmem_we, dmem_be, mem_stall, wb_valid, wb_reg_write,
                  wb_memto_reg, wb_wreg, wb_alu_out, wb_rdata, mis_act}), 128'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // ALU op: single-cycle, never stalls
      s0 = stall_cnt;
      push(1'b1, 1'b0, 5'd7, 32'h0000_1234, 32'd0, 1'b0);
      send(32'h0000_1234, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
      drain();
      check("alu_latency", 128'(last_pop), 128'(accept_cyc));
      check("alu_no_stall", 128'(stall_cnt - s0), 128'd0);
      check("fwd_idle", 128'(fwd_reg_write), 128'd0);

      // Store byte at 0x103, ready on first BUSY cycle
      ready_lat = 1;
      s0 = stall_cnt;
      push(1'b0, 1'b0, 5'd3, 32'h0000_0103, 32'd0, 1'b0);
      send(32'h0000_0103, 32'h0000_00AB, 5'd3, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      drain();
      check("sb_be", 128'(cap_be), 128'h8);
      check("sb_wdata", 128'(cap_wd), 128'hABAB_ABAB);
      check("sb_we_addr", 128'({cap_we, cap_addr}), 128'({1'b1, 32'h0000_0103}));
      check("sb_stall", 128'(stall_cnt - s0), 128'd1);

      // Signed / unsigned halfword load at 0x102, 3 BUSY cycles
      ready_lat = 3;
      dmem_rdata = 32'h8001_0000;
      s0 = stall_cnt;
      push(1'b1, 1'b1, 5'd9, 32'h0000_0102, 32'hFFFF_8001, 1'b0);
      send(32'h0000_0102, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
      drain();
      check("lh_stall", 128'(stall_cnt - s0), 128'd3);
      check("lh_be_we", 128'({cap_we, cap_be}), 128'({1'b0, 4'hC}));
      push(1'b1, 1'b1, 5'd10, 32'h0000_0102, 32'h0000_8001, 1'b0);
      send(32'h0000_0102, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
      drain();

      // Signed byte at lane 1 and word load
      ready_lat = 2;
      dmem_rdata = 32'h0000_8000;
      push(1'b1, 1'b1, 5'd11, 32'h0000_0101, 32'hFFFF_FF80, 1'b0);
      send(32'h0000_0101, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      drain();
      dmem_rdata = 32'h1234_5678;
      push(1'b1, 1'b1, 5'd12, 32'h0000_0100, 32'h1234_5678, 1'b0);
      send(32'h0000_0100, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      drain();

`ifndef MEM_ALIGN_CHECK_EN
      // Misaligned word store: enables truncated at the word boundary
      ready_lat = 1;
      push(1'b0, 1'b0, 5'd13, 32'h0000_0102, 32'd0, 1'b0);
      send(32'h0000_0102, 32'hDEAD_BEEF, 5'd13, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
      drain();
      check("mis_store_be", 128'(cap_be), 128'hC);
      check("mis_store_wd", 128'(cap_wd), 128'hDEAD_BEEF);
`else
      // Misaligned word load trapped without a bus request
      r0 = req_cycles;
      push(1'b0, 1'b0, 5'd13, 32'h0000_0101, 32'd0, 1'b1);
      send(32'h0000_0101, 32'd0, 5'd13, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      drain();
      check("mis_no_req", 128'(req_cycles - r0), 128'd0);
      check("mis_latency", 128'(last_pop), 128'(accept_cyc));
`endif

      // Back-to-back: load, then ALU op held during the stall
      ready_lat = 2;
      dmem_rdata = 32'h0000_0055;
      push(1'b1, 1'b1, 5'd14, 32'h0000_0200, 32'h0000_0055, 1'b0);
      push(1'b1, 1'b0, 5'd15, 32'h0000_BEEF, 32'd0, 1'b0);
      send(32'h0000_0200, 32'd0, 5'd14, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      send(32'h0000_BEEF, 32'd0, 5'd15, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
      drain();
      check("b2b_gap", 128'(last_pop - prev_pop), 128'd1);

      // Reset on the second BUSY cycle abandons the access
      ready_lat = 1000;
      send(32'h0000_0300, 32'd0, 5'd16, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst_busy", 128'({dmem_req, wb_valid, mem_stall}), 128'd0);
      @(posedge clock);
      #1;
      ready_lat = 1;
      push(1'b1, 1'b0, 5'd17, 32'h0000_4321, 32'd0, 1'b0);
      send(32'h0000_4321, 32'd0, 5'd17, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
      drain();

      repeat (3) @(posedge clock);
      check("all_popped", 128'(popped), 128'(pushed));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
